seq_alu: RTL and testbench

Multi-cycle, parametrised ALU for the datapath. It registers its operands and result behind a valid/ready handshake on both input and output. Add, sub, and, or and the shifts complete in one cycle. Signed multiply (shift-add) and signed divide (restoring) are iterative and take WIDTH cycles. The result and the N/Z/C/V flags are registered and held until the consumer accepts them.

---
 rtl/seq_alu.sv | 254 +++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU behind valid/ready handshakes on its
// input and output. Ops: add/sub/and/or/shl/asr (1 cycle), mul/div
// (WIDTH cycles, shift-add and restoring on operand magnitudes).
// Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b,
// ALUControl; out_valid/out_ready, result, overflow, carry, negative,
// zero. Optional macro SEQ_ALU_REMAINDER_EN adds the remainder port.
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             carry,
   output logic             negative,
   output logic             zero
`ifdef SEQ_ALU_REMAINDER_EN
   ,
   output logic [WIDTH-1:0] remainder
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_ASR = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]      count;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplr;
   logic [WIDTH-1:0]   rem_r, quo, dvs;

   logic accept, iter_op, last, load;

   assign accept  = in_valid && in_ready;
   assign iter_op = (ALUControl == OP_DIV) || (ALUControl == OP_MUL);
   assign last    = (state == CALC) && (count == CW'(1));
   assign load    = (accept && !iter_op) || last;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = iter_op ? CALC : DONE;
         CALC:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // ---------------- single-cycle ops ----------------
   logic [SHW-1:0]        shamt;
   logic                  big;
   logic [WIDTH:0]        add_w, sub_w, shl_w;
   logic signed [WIDTH:0] asr_w;

   assign shamt = b[SHW-1:0];
   // Nonzero bits above the shift field count as an oversized shift.
   assign big   = (|b[WIDTH-1:SHW]) || (shamt >= SHW'(WIDTH));
   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};
   // One extra bit captures the last bit shifted out.
   assign shl_w = {1'b0, a} << shamt;
   assign asr_w = $signed({a, 1'b0}) >>> shamt;

   logic [WIDTH-1:0] f_res;
   logic             f_c, f_v;

   always_comb begin
      f_res = '0;
      f_c   = 1'b0;
      f_v   = 1'b0;
      case (ALUControl)
         OP_ADD: begin
            f_res = add_w[MSB:0];
            f_c   = add_w[WIDTH];
            f_v   = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
         end
         OP_SUB: begin
            f_res = sub_w[MSB:0];
            f_c   = ~sub_w[WIDTH];
            f_v   = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
         end
         OP_AND: f_res = a & b;
         OP_OR:  f_res = a | b;
         OP_SHL: begin
            if (!big) begin
               f_res = shl_w[MSB:0];
               f_c   = shl_w[WIDTH];
            end
            f_v = (a[MSB] != f_res[MSB]);
         end
         OP_ASR: begin
            if (big) begin
               f_res = {WIDTH{a[MSB]}};
               f_c   = a[MSB];
            end else begin
               f_res = asr_w[WIDTH:1];
               f_c   = asr_w[0];
            end
         end
         default: ;
      endcase
   end

   // ---------------- iterative engine ----------------
   logic [WIDTH-1:0]   ma, mb;
   logic               neg_q;
   logic [2*WIDTH-1:0] mul_sum, prod;
   logic [WIDTH:0]     rs, df;
   logic               ge;
   logic [WIDTH-1:0]   rem_n, quo_n, quo_s;

   assign ma    = a[MSB] ? -a : a;
   assign mb    = b[MSB] ? -b : b;
   assign neg_q = a_q[MSB] ^ b_q[MSB];

   assign mul_sum = acc + (mplr[0] ? mcand : '0);
   assign prod    = neg_q ? -mul_sum : mul_sum;

   // Restoring step: shift next dividend bit in, subtract if it fits.
   assign rs    = {rem_r, quo[MSB]};
   assign df    = rs - {1'b0, dvs};
   assign ge    = ~df[WIDTH];
   assign rem_n = ge ? df[MSB:0] : rs[MSB:0];
   assign quo_n = {quo[MSB-1:0], ge};
   assign quo_s = neg_q ? -quo_n : quo_n;

   logic [WIDTH-1:0] e_res;
   logic             e_c, e_v;

   always_comb begin
      e_res = '0;
      e_c   = 1'b0;
      e_v   = 1'b0;
      if (op_q == OP_MUL) begin
         e_res = prod[MSB:0];
         e_c   = |prod[2*WIDTH-1:WIDTH];
         e_v   = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[MSB]}};
      end else if (b_q == '0) begin
         e_v = 1'b1;
      end else begin
         e_res = quo_s;
         e_v   = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
      end
   end

   logic [WIDTH-1:0] d_res;
   logic             d_c, d_v;

   assign d_res = (state == CALC) ? e_res : f_res;
   assign d_c   = (state == CALC) ? e_c : f_c;
   assign d_v   = (state == CALC) ? e_v : f_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         mcand <= '0;
         mplr  <= '0;
         rem_r <= '0;
         quo   <= '0;
         dvs   <= '0;
      end else if (accept) begin
         count <= CW'(WIDTH);
         op_q  <= ALUControl;
         a_q   <= a;
         b_q   <= b;
         acc   <= '0;
         mcand <= {{WIDTH{1'b0}}, ma};
         mplr  <= mb;
         rem_r <= '0;
         quo   <= ma;
         dvs   <= mb;
      end else if (state == CALC) begin
         count <= count - CW'(1);
         acc   <= mul_sum;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         rem_r <= rem_n;
         quo   <= quo_n;
      end
   end

   // ---------------- result registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         negative <= 1'b0;
         zero     <= 1'b0;
      end else if (load) begin
         result   <= d_res;
         carry    <= d_c;
         overflow <= d_v;
         negative <= d_res[MSB];
         zero     <= (d_res == '0);
      end
   end

`ifdef SEQ_ALU_REMAINDER_EN
   logic [WIDTH-1:0] rem_s, d_rem;

   // Remainder follows the sign of the dividend.
   assign rem_s = a_q[MSB] ? -rem_n : rem_n;

   always_comb begin
      d_rem = '0;
      if (state == CALC && op_q == OP_DIV)
         d_rem = (b_q == '0) ? a_q : rem_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    remainder <= '0;
      else if (load) remainder <= d_rem;
   end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed, table-driven self-checking bench for seq_alu
// (WIDTH=8), plus hand sequences for hold, busy and mid-op reset.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [2:0] ALUControl;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       overflow, carry, negative, zero;
`ifdef SEQ_ALU_REMAINDER_EN
   logic [7:0] remainder;
`endif

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .ALUControl(ALUControl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .overflow(overflow),
      .carry(carry),
      .negative(negative),
      .zero(zero)
`ifdef SEQ_ALU_REMAINDER_EN
      ,
      .remainder(remainder)
`endif
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       v;
      int         lat;
      logic [7:0] rem;
   } vec_t;

   localparam int NV = 22;
   vec_t tv[NV];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] op, input logic [7:0] ia,
                           input logic [7:0] ib);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_before_op", in_ready, 1);
      in_valid   = 1'b1;
      ALUControl = op;
      a          = ia;
      b          = ib;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      ALUControl = ~op;
      a          = 8'($urandom);
      b          = 8'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("drain_out_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 1);
   endtask

   initial begin
      int lat;
      logic [3:0] exp_f;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      ALUControl = 3'b000;
      a          = '0;
      b          = '0;
      out_ready  = 1'b0;

      //          op      a      b      res    c     v    lat rem
      tv[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1, 8'h00};
      tv[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1, 8'h00};
      tv[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1, 8'h00};
      tv[3]  = '{3'b101, 8'hF8, 8'h14, 8'h60, 1'b1, 1'b1, 9, 8'h00};
      tv[4]  = '{3'b100, 8'hF9, 8'h02, 8'hFD, 1'b0, 1'b0, 9, 8'hFF};
      tv[5]  = '{3'b100, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 9, 8'h00};
      tv[6]  = '{3'b100, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 9, 8'h05};
      tv[7]  = '{3'b110, 8'h41, 8'h01, 8'h82, 1'b0, 1'b1, 1, 8'h00};
      tv[8]  = '{3'b111, 8'h81, 8'h09, 8'hFF, 1'b1, 1'b0, 1, 8'h00};
      tv[9]  = '{3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1, 8'h00};
      tv[10] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1, 8'h00};
      tv[11] = '{3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1, 8'h00};
      tv[12] = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1, 8'h00};
      tv[13] = '{3'b110, 8'h81, 8'h01, 8'h02, 1'b1, 1'b1, 1, 8'h00};
      tv[14] = '{3'b111, 8'h81, 8'h01, 8'hC0, 1'b1, 1'b0, 1, 8'h00};
      tv[15] = '{3'b110, 8'h01, 8'h10, 8'h00, 1'b0, 1'b0, 1, 8'h00};
      tv[16] = '{3'b101, 8'h07, 8'h09, 8'h3F, 1'b0, 1'b0, 9, 8'h00};
      tv[17] = '{3'b101, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 9, 8'h00};
      tv[18] = '{3'b100, 8'h64, 8'hF9, 8'hF2, 1'b0, 1'b0, 9, 8'h02};
      tv[19] = '{3'b110, 8'h01, 8'h07, 8'h80, 1'b0, 1'b1, 1, 8'h00};
      tv[20] = '{3'b111, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 1, 8'h00};
      tv[21] = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1, 8'h00};

      #12;
      chk("reset_result", result, 0);
      chk("reset_flags", {overflow, carry, negative, zero}, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
`ifdef SEQ_ALU_REMAINDER_EN
      chk("reset_rem", remainder, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         start_op(tv[i].op, tv[i].a, tv[i].b);
         wait_done(lat);
         exp_f = {tv[i].v, tv[i].c, tv[i].res[7], tv[i].res == 8'h00};
         chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
         chk($sformatf("v%0d_result", i), result, tv[i].res);
         chk($sformatf("v%0d_flags_vcnz", i),
             {overflow, carry, negative, zero}, exp_f);
`ifdef SEQ_ALU_REMAINDER_EN
         chk($sformatf("v%0d_rem", i), remainder, tv[i].rem);
`endif
         drain();
      end

      // Result held while consumer stalls; new requests ignored.
      start_op(3'b101, 8'hF8, 8'h14);
      wait_done(lat);
      chk("hold_latency", lat, 9);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         ALUControl = 3'b000;
         a          = 8'h01;
         b          = 8'h01;
         chk($sformatf("hold%0d_result", k), result, 8'h60);
         chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
         chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
      end
      in_valid = 1'b0;
      #1;
      drain();

      // Requests during CALC are ignored; captured opcode governs.
      start_op(3'b101, 8'h07, 8'h09);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         ALUControl = 3'b000;
         a          = 8'h11;
         b          = 8'h22;
         chk($sformatf("busy%0d_in_ready", k), in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(lat);
      chk("busy_out_valid", out_valid, 1);
      chk("busy_result", result, 8'h3F);
      drain();

      // Asynchronous reset in the middle of a multiply.
      start_op(3'b101, 8'h07, 8'h09);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_result", result, 0);
      chk("midrst_flags", {overflow, carry, negative, zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(3'b101, 8'h07, 8'h09);
      wait_done(lat);
      chk("postrst_latency", lat, 9);
      chk("postrst_result", result, 8'h3F);
      chk("postrst_flags", {overflow, carry, negative, zero}, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
